imem_burst_responder: RTL and testbench
=======================================

// Module: imem_burst_responder
// PURPOSE
//  Memory-side responder for the instruction-cache line-fill interface. The cache raises mem_req
//  with a block-aligned mem_addr. This block waits a fixed access latency, then streams
//  BLOCK_SIZE consecutive words, one per mem_val beat, lowest address first. It then waits
//  for mem_req to drop before accepting the next request. Backing store is a word RAM that
//  the testbench or boot logic fills through a load port.
// PARAMETERS
//  BLOCK_SIZE  8     words per burst (power of 2; cache line = BLOCK_SIZE*4 bytes)
//  ADDR_W      10    word-address bits of backing RAM (depth = 2**ADDR_W words)
//  LATENCY     4     cycles from request accept to first beat (>=1)
//  BEAT_GAP    0     idle cycles inserted between consecutive beats (0 = back-to-back)
// PORTS
//  clk        in   1   clock
//  reset      in   1   synchronous, active-high reset
//  mem_req    in   1   line-fill request, level; held by requester until burst consumed
//  mem_addr   in   32  byte address of line; bits [log2(BLOCK_SIZE)+1:0] ignored (forced 0)
//  mem_data   out  32  burst word; valid only while mem_val=1, else 32'b0
//  mem_val    out  1   one-cycle strobe per delivered word
//  busy       out  1   high in every state except IDLE
//  ld_en      in   1   backing-RAM write enable
//  ld_addr    in   ADDR_W  word address for load
//  ld_data    in   32  load data
// BEHAVIOUR
//  - Reset: state=IDLE, mem_val=0, mem_data=0, busy=0, counters=0. RAM contents not cleared.
//    Reset mid-burst aborts at once; no further beats.
//  - FSM: IDLE -> WAIT -> BURST -> DRAIN -> IDLE.
//    IDLE : at an edge where mem_req=1, latch base = mem_addr[ADDR_W+1:2] with the low
//           log2(BLOCK_SIZE) bits zeroed; set lat_cnt=0; go to WAIT.
//    WAIT : lat_cnt counts up; at lat_cnt==LATENCY-1 go to BURST.
//           First mem_val comes exactly LATENCY cycles after the accept edge.
//    BURST: beat k (k=0..BLOCK_SIZE-1) drives mem_data=RAM[base+k], mem_val=1 for one cycle.
//           BEAT_GAP idle cycles (mem_val=0) separate beats. No gap after the last beat.
//           After the last beat go to DRAIN.
//    DRAIN: ignore mem_req while it stays 1 (requester drops it ~2 cycles after the last beat).
//           Go to IDLE on the first cycle mem_req=0. A new request is accepted no earlier
//           than the cycle after that.
//  - Requester abort: mem_req=0 in WAIT or BURST -> next cycle IDLE with mem_val=0.
//    Remaining beats are discarded and no partial state is retained.
//  - mem_data/mem_val are registered outputs. RAM read is synchronous, so the read address
//    is issued one cycle before the beat.
//  - Address arithmetic is modulo 2**ADDR_W. base+k never carries out of the line.
//    Addresses above the RAM depth alias.
//  - Load port is independent of FSM state. A write takes effect at the edge.
//    A burst read of the same word in the same cycle returns the old value.
//  - Beat counter width is log2(BLOCK_SIZE)+1. Exactly BLOCK_SIZE beats per completed burst.
// STRUCTURE
//  - Shared package: state enum {IDLE,WAIT,BURST,DRAIN}, BLOCK_SIZE, and the line-offset
//    width shared with the cache.
//  - One sub-module: imem_word_ram (1 sync read port, 1 write port, ADDR_W x 32).
//  - FSM, latency/gap/beat counters and output registers stay in this module.
// TESTING
//  1. Load RAM[i]=32'h1000_0000+i for i=0..1023; pulse mem_req with addr 32'h0000_0040 and
//     hold until 2 cycles after the last val. Expect 8 beats of 10000010..10000017, the first
//     4 cycles after accept, back-to-back.
//  2. Unaligned addr 32'h0000_005C -> same 8 words as addr 32'h40 (offset ignored).
//  3. BEAT_GAP=2, LATENCY=1: addr 0 -> mem_val at accept+1,+4,+7,...,+22; 8 beats total.
//  4. Hold mem_req=1 for 5 cycles after the last beat. Expect no second burst; busy=1 until
//     mem_req=0, then busy=0 the next cycle.
//  5. Drop mem_req after beat 3. Expect no further mem_val. A new request at addr 32'h80 then
//     returns 10000020..10000027.
//  6. Assert reset during beat 5. Expect mem_val=0, busy=0 the next cycle; a following request
//     at addr 0 returns a full 8-word burst. Also ld_en to RAM[9]=DEADBEEF mid-idle is
//     visible in the next burst at addr 32'h20.

Source files
------------

// File: rtl/imem_burst_responder_pkg.sv
// Shared definitions for the instruction-memory line-fill responder and its cache-side peer.
package imem_burst_responder_pkg;
  localparam int IMEM_BLOCK_SIZE = 8;
  localparam int IMEM_OFF_W      = $clog2(IMEM_BLOCK_SIZE);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DRAIN} imem_state_e;
endpackage

// File: rtl/imem_word_ram.sv
// 32-bit word RAM: one synchronous read port, one write port.
// The read register returns zero on cycles without a read.
module imem_word_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data
);
  logic [31:0] mem [2**ADDR_W];

  // Contents are never reset; the read returns the pre-write value on a same-address collision.
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;

  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
    else            rd_data <= '0;
  end
endmodule

// File: rtl/imem_burst_responder.sv
// Line-fill responder: after LATENCY cycles streams BLOCK_SIZE words of a line, one per
// mem_val beat, then holds busy until the requester drops mem_req. BLOCK_SIZE must be >= 2.
module imem_burst_responder
  import imem_burst_responder_pkg::*;
#(
  parameter int BLOCK_SIZE = IMEM_BLOCK_SIZE,
  parameter int ADDR_W     = 10,
  parameter int LATENCY    = 4,
  parameter int BEAT_GAP   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req,
  input  logic [31:0]       mem_addr,
  output logic [31:0]       mem_data,
  output logic              mem_val,
  output logic              busy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data
);
  localparam int OFF_W  = $clog2(BLOCK_SIZE);
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int GAP_W  = (BEAT_GAP > 0) ? $clog2(BEAT_GAP + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(LATENCY - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(BEAT_GAP);
  localparam logic [OFF_W:0]   BEAT_LAST = (OFF_W + 1)'(BLOCK_SIZE - 1);

  imem_state_e       state, state_nxt;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic [OFF_W:0]    beat_cnt, beat_cnt_nxt;
  logic [LINE_W-1:0] line_q, line_nxt;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              val_q;
  logic              unused_addr;

  assign unused_addr = ^{mem_addr[31:ADDR_W+2], mem_addr[OFF_W+1:0]};

  // rd_en marks the cycle before a beat: the RAM read register becomes the beat data.
  always_comb begin
    state_nxt    = state;
    lat_cnt_nxt  = lat_cnt;
    gap_cnt_nxt  = gap_cnt;
    beat_cnt_nxt = beat_cnt;
    line_nxt     = line_q;
    rd_en        = 1'b0;
    case (state)
      IDLE: if (mem_req) begin
        state_nxt    = WAIT;
        lat_cnt_nxt  = '0;
        gap_cnt_nxt  = '0;
        beat_cnt_nxt = '0;
        line_nxt     = mem_addr[ADDR_W+1:OFF_W+2];
      end
      WAIT: begin
        if (!mem_req)                state_nxt = IDLE;
        else if (lat_cnt == LAT_LAST) begin
          rd_en     = 1'b1;
          state_nxt = BURST;
        end
        else                         lat_cnt_nxt = lat_cnt + 1'b1;
      end
      BURST: begin
        if (!mem_req)             state_nxt = IDLE;
        else if (gap_cnt != '0)   gap_cnt_nxt = gap_cnt - 1'b1;
        else                      rd_en = 1'b1;
      end
      DRAIN: if (!mem_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rd_en) begin
      beat_cnt_nxt = beat_cnt + 1'b1;
      gap_cnt_nxt  = GAP_LOAD;
      if (beat_cnt == BEAT_LAST) state_nxt = DRAIN;
    end
  end

  assign rd_addr = {line_q, beat_cnt[OFF_W-1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      gap_cnt  <= '0;
      beat_cnt <= '0;
      line_q   <= '0;
      val_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      lat_cnt  <= lat_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      beat_cnt <= beat_cnt_nxt;
      line_q   <= line_nxt;
      val_q    <= rd_en;
    end
  end

  imem_word_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (mem_data),
    .wr_en   (ld_en),
    .wr_addr (ld_addr),
    .wr_data (ld_data)
  );

  assign mem_val = val_q;
  assign busy    = (state != IDLE);
endmodule

// File: tb/tb_imem_burst_responder.sv
// Bench for imem_burst_responder: cycle-arithmetic reference model plus directed bursts.
module tb_imem_burst_responder;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_req0 = 1'b0, mem_req1 = 1'b0;
  logic [31:0] mem_addr0 = '0, mem_addr1 = '0;
  logic [31:0] mem_data0, mem_data1;
  logic mem_val0, mem_val1, busy0, busy1;
  logic ld_en = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [31:0] ld_data = '0;

  always #5 clk = ~clk;

  imem_burst_responder #(.BLOCK_SIZE(8), .ADDR_W(ADDR_W), .LATENCY(4), .BEAT_GAP(0)) dut0 (
    .clk(clk), .reset(reset), .mem_req(mem_req0), .mem_addr(mem_addr0),
    .mem_data(mem_data0), .mem_val(mem_val0), .busy(busy0),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  imem_burst_responder #(.BLOCK_SIZE(8), .ADDR_W(ADDR_W), .LATENCY(1), .BEAT_GAP(2)) dut1 (
    .clk(clk), .reset(reset), .mem_req(mem_req1), .mem_addr(mem_addr1),
    .mem_data(mem_data1), .mem_val(mem_val1), .busy(busy1),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: beat k of a burst accepted at edge A appears at edge
  // A + LAT + k*(GAP+1) if the request is still held; any edge with req low ends it.
  logic [31:0] ram_m [DEPTH];
  bit          mb [2];
  int          macc [2];
  int          mbase [2];
  bit          ev [2];
  logic [31:0] ed [2];
  bit          eb [2];

  initial begin
    int off, k, lat, gap;
    logic req;
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) ram_m[i] = '0;
    for (int d = 0; d < 2; d++) begin mb[d] = 0; ev[d] = 0; ed[d] = '0; eb[d] = 0; end
    forever begin
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        req = (d == 1) ? mem_req1 : mem_req0;
        a   = (d == 1) ? mem_addr1 : mem_addr0;
        lat = (d == 1) ? 1 : 4;
        gap = (d == 1) ? 2 : 0;
        ev[d] = 0;
        ed[d] = '0;
        if (reset) mb[d] = 0;
        else if (!mb[d]) begin
          if (req === 1'b1) begin
            mb[d] = 1;
            macc[d] = cyc;
            mbase[d] = int'((((a / 4) / 8) * 8) % DEPTH);
          end
        end
        else if (req !== 1'b1) mb[d] = 0;
        else begin
          off = cyc - macc[d];
          if (off >= lat && off <= lat + 7 * (gap + 1) && (off - lat) % (gap + 1) == 0) begin
            k = (off - lat) / (gap + 1);
            ev[d] = 1;
            ed[d] = ram_m[(mbase[d] + k) % DEPTH];
          end
        end
        eb[d] = mb[d];
      end
      if (ld_en) ram_m[ld_addr] = ld_data;
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("val0", 32'(mem_val0), 32'(ev[0]));
      chk("data0", mem_data0, ed[0]);
      chk("busy0", 32'(busy0), 32'(eb[0]));
      chk("val1", 32'(mem_val1), 32'(ev[1]));
      chk("data1", mem_data1, ed[1]);
      chk("busy1", 32'(busy1), 32'(eb[1]));
    end
  end

  // Beat logs for the directed literal checks.
  logic [31:0] bd0[$], bd1[$];
  int          bc0[$], bc1[$];

  initial forever begin
    @(negedge clk);
    if (mem_val0 === 1'b1) begin bd0.push_back(mem_data0); bc0.push_back(cyc); end
    if (mem_val1 === 1'b1) begin bd1.push_back(mem_data1); bc1.push_back(cyc); end
  end

  function automatic int nbeats(input int sel);
    return (sel == 1) ? bc1.size() : bc0.size();
  endfunction

  // Raise req, wait for nb beats (bounded), hold req for 'hold' more edges, then drop it.
  task automatic burst(input int sel, input logic [31:0] addr, input int nb, input int hold,
                       output int acc);
    int n;
    if (sel == 1) begin bd1.delete(); bc1.delete(); end
    else          begin bd0.delete(); bc0.delete(); end
    @(posedge clk); #1;
    if (sel == 1) begin mem_req1 = 1'b1; mem_addr1 = addr; end
    else          begin mem_req0 = 1'b1; mem_addr0 = addr; end
    acc = cyc + 1;
    n = 0;
    while (nbeats(sel) < nb && n < 200) begin @(negedge clk); #1; n++; end
    chk("beats_seen", 32'(nbeats(sel)), 32'(nb));
    if (hold > 0) begin repeat (hold) @(posedge clk); #1; end
    if (sel == 1) mem_req1 = 1'b0;
    else          mem_req0 = 1'b0;
  endtask

  initial begin
    int acc, n;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_val", 32'(mem_val0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_data", mem_data0, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      ld_en = 1'b1; ld_addr = ADDR_W'(i); ld_data = 32'h1000_0000 + 32'(i);
    end
    @(posedge clk); #1 ld_en = 1'b0;
    repeat (3) @(posedge clk);

    // Aligned line, back-to-back beats, first beat 4 cycles after accept.
    burst(0, 32'h0000_0040, 8, 2, acc);
    chk("t1_first_lat", 32'(bc0[0] - acc), 32'd4);
    for (int k = 0; k < 8; k++) begin
      chk("t1_data", bd0[k], 32'h1000_0010 + 32'(k));
      chk("t1_spacing", 32'(bc0[k] - bc0[0]), 32'(k));
    end
    repeat (3) @(posedge clk);

    // Unaligned address: offset bits ignored.
    burst(0, 32'h0000_005C, 8, 2, acc);
    chk("t2_first", bd0[0], 32'h1000_0010);
    chk("t2_last", bd0[7], 32'h1000_0017);
    repeat (3) @(posedge clk);

    // Gapped responder: beats at accept+1,+4,...,+22.
    burst(1, 32'h0000_0000, 8, 2, acc);
    for (int k = 0; k < 8; k++) begin
      chk("t3_time", 32'(bc1[k] - acc), 32'(1 + 3 * k));
      chk("t3_data", bd1[k], 32'h1000_0000 + 32'(k));
    end
    repeat (3) @(posedge clk);

    // Long hold after the burst: no second burst, busy until req drops.
    burst(0, 32'h0000_0040, 8, 5, acc);
    chk("t4_no_rerun", 32'(bd0.size()), 32'd8);
    chk("t4_busy_held", 32'(busy0), 32'd1);
    @(posedge clk); #1;
    chk("t4_busy_drop", 32'(busy0), 32'd0);
    repeat (3) @(posedge clk);

    // Abort after beat index 3, then a fresh request.
    burst(0, 32'h0000_0040, 4, 0, acc);
    repeat (12) @(posedge clk);
    chk("t5_abort_cnt", 32'(bd0.size()), 32'd4);
    chk("t5_beat3", bd0[3], 32'h1000_0013);
    chk("t5_idle", 32'(busy0), 32'd0);
    burst(0, 32'h0000_0080, 8, 2, acc);
    chk("t5_first", bd0[0], 32'h1000_0020);
    chk("t5_last", bd0[7], 32'h1000_0027);
    repeat (3) @(posedge clk);

    // Reset during beat 5.
    bd0.delete(); bc0.delete();
    @(posedge clk); #1;
    mem_req0 = 1'b1; mem_addr0 = 32'h0;
    n = 0;
    while (bc0.size() < 6 && n < 200) begin @(negedge clk); #1; n++; end
    chk("t6_pre_beats", 32'(bc0.size()), 32'd6);
    reset = 1'b1; mem_req0 = 1'b0;
    @(negedge clk);
    chk("t6_val", 32'(mem_val0), 32'd0);
    chk("t6_busy", 32'(busy0), 32'd0);
    chk("t6_data", mem_data0, 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    burst(0, 32'h0000_0000, 8, 2, acc);
    chk("t6_first", bd0[0], 32'h1000_0000);
    chk("t6_last", bd0[7], 32'h1000_0007);
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_addr = ADDR_W'(9); ld_data = 32'hDEAD_BEEF;
    @(posedge clk); #1 ld_en = 1'b0;
    repeat (2) @(posedge clk);
    burst(0, 32'h0000_0020, 8, 2, acc);
    chk("t6_ld_w8", bd0[0], 32'h1000_0008);
    chk("t6_ld_w9", bd0[1], 32'hDEAD_BEEF);
    chk("t6_ld_w10", bd0[2], 32'h1000_000A);
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
